remote_comm: RTL and testbench

REMOTE_COMM -- requirements
Module: remote_comm

---
 rtl/remote_comm_pkg.sv | 26 ++
 rtl/remote_comm_uart_tx_rx.sv | 137 +++++++++++++
 rtl/remote_comm.sv | 141 ++++++++++++++
 tb/tb_remote_comm.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/remote_comm_pkg.sv
// remote_comm_pkg
// Shared types and constants for the remote command link.
//   tx_state_t       : two-byte command sequencer states (IDLE, HIGH, LOW, DONE)
//   rx_state_t       : byte receiver states (IDLE, START, DATA, STOP)
//   BAUD_DIV_DEFAULT : default clocks per UART bit
//   CNT_W            : width of the baud counters
package remote_comm_pkg;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_HIGH = 2'd1,
    TX_LOW  = 2'd2,
    TX_DONE = 2'd3
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  localparam int BAUD_DIV_DEFAULT = 434;
  localparam int CNT_W            = 16;

endpackage

// File: rtl/remote_comm_uart_tx_rx.sv
// uart_tx_rx
// Byte-level 8N1 UART transmitter and receiver, LSB first, BAUD_DIV clocks per bit.
// The two halves share nothing but clock and reset.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   tx_start  : load tx_data and begin a frame; honoured when idle or on tx_done
//   tx_data   : byte to transmit
//   tx        : serial out (registered, idle high)
//   tx_done   : high on the last clock of the stop bit; a new tx_start on that
//               cycle chains the next frame with no idle gap
//   rx        : serial in, already registered by the caller
//   rx_valid  : high on the mid-stop sample cycle; rx_data is complete then
//   rx_data   : received byte
module uart_tx_rx
  import remote_comm_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       tx_done,
  input  logic       rx,
  output logic       rx_valid,
  output logic [7:0] rx_data
);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);

  logic             tx_busy;
  logic [CNT_W-1:0] tx_cnt;
  logic [3:0]       tx_bit;
  logic [9:0]       tx_frame;

  rx_state_t        rx_state;
  rx_state_t        rx_next;
  logic [CNT_W-1:0] rx_cnt;
  logic [2:0]       rx_bit;
  logic [7:0]       rx_shift;
  logic             rx_prev;

  assign tx_done  = tx_busy && (tx_cnt == BIT_LAST) && (tx_bit == 4'd9);
  assign rx_valid = (rx_state == RX_STOP) && (rx_cnt == BIT_LAST);
  assign rx_data  = rx_shift;

  // Transmit shifter: frame held as {stop, data, start}, shifted out LSB first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_busy  <= 1'b0;
      tx_cnt   <= '0;
      tx_bit   <= 4'd0;
      tx_frame <= 10'h3FF;
      tx       <= 1'b1;
    end else if (tx_start && (!tx_busy || tx_done)) begin
      tx_busy  <= 1'b1;
      tx_cnt   <= '0;
      tx_bit   <= 4'd0;
      tx_frame <= {1'b1, tx_data, 1'b0};
      tx       <= 1'b0;
    end else if (tx_busy) begin
      if (tx_cnt == BIT_LAST) begin
        tx_cnt <= '0;
        if (tx_bit == 4'd9) begin
          tx_busy <= 1'b0;
          tx_bit  <= 4'd0;
          tx      <= 1'b1;
        end else begin
          tx_bit   <= tx_bit + 4'd1;
          tx_frame <= {1'b1, tx_frame[9:1]};
          tx       <= tx_frame[1];
        end
      end else begin
        tx_cnt <= tx_cnt + CNT_W'(1);
      end
    end
  end

  // Receive state register plus edge-detect history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state <= RX_IDLE;
      rx_prev  <= 1'b1;
    end else begin
      rx_state <= rx_next;
      rx_prev  <= rx;
    end
  end

  // Receive next-state: a high sample at mid-start means a glitch, drop back to idle.
  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE: begin
        if (rx_prev && !rx) rx_next = RX_START;
        else                rx_next = RX_IDLE;
      end
      RX_START: begin
        if (rx_cnt == HALF_LAST) rx_next = rx ? RX_IDLE : RX_DATA;
        else                     rx_next = RX_START;
      end
      RX_DATA: begin
        if ((rx_cnt == BIT_LAST) && (rx_bit == 3'd7)) rx_next = RX_STOP;
        else                                          rx_next = RX_DATA;
      end
      RX_STOP: begin
        if (rx_cnt == BIT_LAST) rx_next = RX_IDLE;
        else                    rx_next = RX_STOP;
      end
      default: rx_next = RX_IDLE;
    endcase
  end

  // Receive counters and shifter; after mid-start every sample is one full bit apart.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_cnt   <= '0;
      rx_bit   <= 3'd0;
      rx_shift <= 8'h00;
    end else begin
      if ((rx_state == RX_IDLE) || (rx_state != rx_next) || (rx_cnt == BIT_LAST)) begin
        rx_cnt <= '0;
      end else begin
        rx_cnt <= rx_cnt + CNT_W'(1);
      end
      if (rx_state != RX_DATA) begin
        rx_bit <= 3'd0;
      end else if (rx_cnt == BIT_LAST) begin
        rx_bit   <= rx_bit + 3'd1;
        rx_shift <= {rx, rx_shift[7:1]};
      end
    end
  end

endmodule

// File: rtl/remote_comm.sv
// remote_comm
// Sends a 16-bit command as two back-to-back UART bytes (high byte first) and
// captures single-byte responses from the remote side.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   cmd       : command word, captured when send_cmd is accepted
//   send_cmd  : start pulse, accepted only in IDLE or DONE
//   RX / TX   : UART serial in / out, idle high
//   cmd_sent  : both command bytes fully transmitted; held until next accepted send
//   resp_rdy  : resp holds a valid byte; cleared by an accepted send
//   resp      : last received byte
// Build option: REMOTE_COMM_RX_SYNC_EN selects a two-flop RX synchronizer
// instead of the default single input flop.
module remote_comm
  import remote_comm_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cmd,
  input  logic        send_cmd,
  input  logic        RX,
  output logic        TX,
  output logic        cmd_sent,
  output logic        resp_rdy,
  output logic [7:0]  resp
);

  tx_state_t   tx_state;
  tx_state_t   tx_next;
  logic [15:0] cmd_reg;
  logic        accept;
  logic        finish;
  logic        byte_start;
  logic [7:0]  byte_data;
  logic        byte_done;
  logic        rx_in;
  logic        rx_valid;
  logic [7:0]  rx_data;

`ifdef REMOTE_COMM_RX_SYNC_EN
  logic [1:0] rx_sync;

  // Two-flop RX synchronizer, preset to the idle level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_sync <= 2'b11;
    else     rx_sync <= {rx_sync[0], RX};
  end
  assign rx_in = rx_sync[1];
`else
  logic rx_sync;

  // Single RX input flop, preset to the idle level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_sync <= 1'b1;
    else     rx_sync <= RX;
  end
  assign rx_in = rx_sync;
`endif

  // Sequencer state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tx_state <= TX_IDLE;
    else     tx_state <= tx_next;
  end

  // Sequencer next-state: the high byte is fed straight from cmd so its start
  // bit leaves on the accepting edge; the low byte chains on the high byte's last clock.
  always_comb begin
    tx_next    = tx_state;
    accept     = 1'b0;
    byte_start = 1'b0;
    byte_data  = cmd_reg[7:0];
    case (tx_state)
      TX_IDLE, TX_DONE: begin
        if (send_cmd) begin
          accept     = 1'b1;
          byte_start = 1'b1;
          byte_data  = cmd[15:8];
          tx_next    = TX_HIGH;
        end else begin
          tx_next = tx_state;
        end
      end
      TX_HIGH: begin
        if (byte_done) begin
          byte_start = 1'b1;
          tx_next    = TX_LOW;
        end else begin
          tx_next = TX_HIGH;
        end
      end
      TX_LOW: begin
        if (byte_done) tx_next = TX_DONE;
        else           tx_next = TX_LOW;
      end
      default: tx_next = TX_IDLE;
    endcase
  end

  assign finish = (tx_state == TX_LOW) && byte_done;

  // Command capture and status flags; a byte arriving on the accept cycle keeps resp_rdy set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_reg  <= 16'h0000;
      cmd_sent <= 1'b0;
      resp_rdy <= 1'b0;
      resp     <= 8'h00;
    end else begin
      if (accept) begin
        cmd_reg  <= cmd;
        cmd_sent <= 1'b0;
      end else if (finish) begin
        cmd_sent <= 1'b1;
      end
      if (rx_valid) begin
        resp     <= rx_data;
        resp_rdy <= 1'b1;
      end else if (accept) begin
        resp_rdy <= 1'b0;
      end
    end
  end

  uart_tx_rx #(
    .BAUD_DIV (BAUD_DIV)
  ) u_uart (
    .clk      (clk),
    .rst      (rst),
    .tx_start (byte_start),
    .tx_data  (byte_data),
    .tx       (TX),
    .tx_done  (byte_done),
    .rx       (rx_in),
    .rx_valid (rx_valid),
    .rx_data  (rx_data)
  );

endmodule

// File: tb/tb_remote_comm.sv
// tb_remote_comm
// Self-checking bench for remote_comm: a table of concurrent send/receive
// vectors plus hand-written sequences for busy-ignore, mid-frame reset and
// false start. TX frames and received bytes are checked against scoreboard queues.
module tb_remote_comm;

  localparam int BD = 434;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cmd;
  logic        send_cmd;
  logic        RX;
  logic        TX;
  logic        cmd_sent;
  logic        resp_rdy;
  logic [7:0]  resp;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int k_cyc    = 0;

  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];

  typedef struct {
    logic [15:0] cmd;
    logic [7:0]  exp_hi;
    logic [7:0]  exp_lo;
    logic [7:0]  rx_byte;
    logic        rx_stop;
    logic [7:0]  exp_resp;
    int          rx_delay;
  } vec_t;

  vec_t vecs[3];

  remote_comm #(.BAUD_DIV(BD)) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd      (cmd),
    .send_cmd (send_cmd),
    .RX       (RX),
    .TX       (TX),
    .cmd_sent (cmd_sent),
    .resp_rdy (resp_rdy),
    .resp     (resp)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // TX frame monitor: samples mid-bit on the falling clock edge and pops the scoreboard.
  initial begin
    int         cnt;
    bit         busy;
    logic       prev;
    logic [9:0] bits;
    logic [7:0] e;
    cnt = 0; busy = 1'b0; prev = 1'b1; bits = 10'h000;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy = 1'b0;
      end else if (!busy) begin
        if (prev && !TX) begin
          busy = 1'b1;
          cnt  = 0;
        end
      end else begin
        cnt++;
        if ((cnt % BD) == (BD / 2)) begin
          bits[cnt / BD] = TX;
          if ((cnt / BD) == 9) begin
            busy = 1'b0;
            if (tx_q.size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL tx_frame: got frame %03h, expected no frame", bits);
            end else begin
              e = tx_q.pop_front();
              check("tx_frame", 32'(bits), 32'({1'b1, e, 1'b0}));
            end
          end
        end
      end
      prev = TX;
    end
  end

  // Response monitor: every new valid response pops the receive scoreboard.
  initial begin
    logic       pr;
    logic [7:0] pv;
    logic [7:0] e;
    pr = 1'b0; pv = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        pr = 1'b0;
        pv = 8'h00;
      end else begin
        if (resp_rdy && (!pr || (resp != pv))) begin
          if (rx_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL resp: got %0h, expected no response", resp);
          end else begin
            e = rx_q.pop_front();
            check("resp", 32'(resp), 32'(e));
          end
        end
        pr = resp_rdy;
        pv = resp;
      end
    end
  end

  task automatic start_send(input logic [15:0] c, input logic [7:0] hi, input logic [7:0] lo);
    @(negedge clk);
    cmd      = c;
    send_cmd = 1'b1;
    @(posedge clk);
    #1;
    k_cyc    = cyc;
    send_cmd = 1'b0;
    tx_q.push_back(hi);
    tx_q.push_back(lo);
    check("tx_start_next_cycle", 32'(TX), 32'd0);
    check("cmd_sent_cleared", 32'(cmd_sent), 32'd0);
    check("resp_rdy_cleared", 32'(resp_rdy), 32'd0);
  endtask

  task automatic wait_sent();
    int d;
    bit done;
    d = 0;
    done = 1'b0;
    while (!done && (d <= 25 * BD)) begin
      @(posedge clk);
      #1;
      d = cyc - k_cyc;
      if (d == 10 * BD - 1) check("hi_stop_bit", 32'(TX), 32'd1);
      if (d == 10 * BD)     check("lo_start_no_gap", 32'(TX), 32'd0);
      if (cmd_sent) done = 1'b1;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL cmd_sent_timeout: got no cmd_sent, expected it after %0d clocks", 20 * BD);
    end else begin
      check("cmd_sent_latency", 32'(d), 32'(20 * BD));
    end
  endtask

  task automatic pulse_ignored(input logic [15:0] c);
    @(negedge clk);
    cmd      = c;
    send_cmd = 1'b1;
    @(negedge clk);
    send_cmd = 1'b0;
    cmd      = 16'h0000;
  endtask

  task automatic drive_rx(input logic [7:0] b, input logic stop_bit, input logic [7:0] exp);
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    rx_q.push_back(exp);
    @(negedge clk);
    for (int j = 0; j < 10; j++) begin
      RX = fr[j];
      if (j < 9) begin
        repeat (BD) @(negedge clk);
      end else begin
        repeat (BD / 2 - 4) @(negedge clk);
        check("resp_rdy_before_mid_stop", 32'(resp_rdy), 32'd0);
        repeat (8) @(negedge clk);
        check("resp_rdy_after_mid_stop", 32'(resp_rdy), 32'd1);
        repeat (BD - BD / 2 - 4) @(negedge clk);
      end
    end
    RX = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{16'h3BF1, 8'h3B, 8'hF1, 8'hA5, 1'b1, 8'hA5, 100};
    vecs[1] = '{16'h3BF1, 8'h3B, 8'hF1, 8'h5A, 1'b1, 8'h5A, 2000};
    vecs[2] = '{16'h00FF, 8'h00, 8'hFF, 8'h3C, 1'b0, 8'h3C, 4000};

    rst      = 1'b1;
    cmd      = 16'h0000;
    send_cmd = 1'b0;
    RX       = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_tx", 32'(TX), 32'd1);
    check("reset_cmd_sent", 32'(cmd_sent), 32'd0);
    check("reset_resp_rdy", 32'(resp_rdy), 32'd0);
    check("reset_resp", 32'(resp), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Table: each command send runs concurrently with one received frame.
    for (int i = 0; i < 3; i++) begin
      fork
        begin
          start_send(vecs[i].cmd, vecs[i].exp_hi, vecs[i].exp_lo);
          wait_sent();
        end
        begin
          repeat (vecs[i].rx_delay) @(negedge clk);
          drive_rx(vecs[i].rx_byte, vecs[i].rx_stop, vecs[i].exp_resp);
        end
      join
      repeat (10) @(negedge clk);
      check("cmd_sent_held", 32'(cmd_sent), 32'd1);
    end

    // Busy ignore: a second pulse during the high byte must not disturb the send.
    start_send(16'h2002, 8'h20, 8'h02);
    repeat (3000) @(posedge clk);
    pulse_ignored(16'h33F2);
    wait_sent();
    repeat (10) @(negedge clk);

    // Reset in the middle of the low byte (data bit 3 of 0x34 is 0).
    start_send(16'h1234, 8'h12, 8'h34);
    while ((cyc - k_cyc) < (10 * BD + 2000)) @(posedge clk);
    #3;
    check("tx_low_before_reset", 32'(TX), 32'd0);
    rst = 1'b1;
    #1;
    check("async_reset_tx", 32'(TX), 32'd1);
    check("async_reset_cmd_sent", 32'(cmd_sent), 32'd0);
    check("async_reset_resp", 32'(resp), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    tx_q.delete();
    repeat (5) @(negedge clk);
    start_send(16'h37F2, 8'h37, 8'hF2);
    wait_sent();
    repeat (10) @(negedge clk);

    // False start: a 100-clock low glitch must not produce a response.
    RX = 1'b0;
    repeat (100) @(negedge clk);
    RX = 1'b1;
    repeat (600) @(negedge clk);
    check("false_start_resp_rdy", 32'(resp_rdy), 32'd0);

    check("tx_queue_drained", 32'(tx_q.size()), 32'd0);
    check("rx_queue_drained", 32'(rx_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
